mul_issue_fifo: RTL and testbench

In-order issue buffer directly upstream of the multiply/divide execute wrapper. It accepts decoded multiply/divide instructions with their operand values, ROB slot and forwarding info from dispatch, holds them while the execute unit stalls, and presents the oldest entry to the unit. A flush input discards all buffered work on pipeline redirect.

---
 rtl/pipTypes_pkg.sv | 38 +++
 rtl/mul_issue_fifo.sv | 92 +++++++++
 tb/tb_mul_issue_fifo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipTypes_pkg.sv
// Shared pipeline types for the multiply/divide issue path: decoded op,
// forwarding info and the issue-buffer entry.
package pipTypes;

   localparam int ROB_DEPTHLOG2 = 4;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_t;

   typedef struct packed {
      md_op_t     op;
      logic [4:0] rd;
   } dec_inst_t;

   typedef struct packed {
      logic                     fwd_a;
      logic [ROB_DEPTHLOG2-1:0] rob_a;
      logic                     fwd_b;
      logic [ROB_DEPTHLOG2-1:0] rob_b;
   } fwd_info_t;

   typedef struct packed {
      dec_inst_t                inst;
      logic [31:0]              a;
      logic [31:0]              b;
      logic [ROB_DEPTHLOG2-1:0] rob_slot;
      fwd_info_t                fwd_info;
   } iq_mul_entry_t;

endpackage

// File: rtl/mul_issue_fifo.sv
// In-order issue buffer feeding the multiply/divide execute wrapper.
// Head payload is read combinationally; flush empties the buffer at the next edge.
module mul_issue_fifo
   import pipTypes::*;
#(
   parameter int IQ_DEPTHLOG2 = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  dec_inst_t                in_inst,
   input  logic [31:0]              in_A,
   input  logic [31:0]              in_B,
   input  logic [ROB_DEPTHLOG2-1:0] in_rob_slot,
   input  fwd_info_t                in_fwd_info,
   output logic                     out_valid,
   input  logic                     out_ready,
   output dec_inst_t                out_inst,
   output logic [31:0]              out_A,
   output logic [31:0]              out_B,
   output logic [ROB_DEPTHLOG2-1:0] out_rob_slot,
   output fwd_info_t                out_fwd_info,
   output logic [IQ_DEPTHLOG2:0]    count
);

   localparam int DEPTH = 1 << IQ_DEPTHLOG2;
   localparam logic [IQ_DEPTHLOG2:0]   FULL_CNT = (IQ_DEPTHLOG2+1)'(DEPTH);
   localparam logic [IQ_DEPTHLOG2:0]   CNT_ONE  = (IQ_DEPTHLOG2+1)'(1);
   localparam logic [IQ_DEPTHLOG2-1:0] PTR_ONE  = IQ_DEPTHLOG2'(1);

   logic [IQ_DEPTHLOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [IQ_DEPTHLOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [IQ_DEPTHLOG2:0]   count_q, count_d;

   iq_mul_entry_t mem_q [DEPTH];
   iq_mul_entry_t in_entry;
   iq_mul_entry_t head;
   logic          full, empty, enq, deq;

   always_comb begin
      full      = (count_q == FULL_CNT);
      empty     = (count_q == '0);
      in_ready  = ~full & ~flush;
      out_valid = ~empty & ~flush;
      enq       = in_valid & in_ready;
      deq       = out_valid & out_ready;

      in_entry = '{inst: in_inst, a: in_A, b: in_B, rob_slot: in_rob_slot, fwd_info: in_fwd_info};
      head     = mem_q[rd_ptr_q];

      wr_ptr_d = enq ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = deq ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      case ({enq, deq})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // flush wins over any handshake; enq/deq are already gated off above
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (enq) mem_q[wr_ptr_q] <= in_entry;
   end

   assign out_inst     = head.inst;
   assign out_A        = head.a;
   assign out_B        = head.b;
   assign out_rob_slot = head.rob_slot;
   assign out_fwd_info = head.fwd_info;
   assign count        = count_q;

endmodule

// File: tb/tb_mul_issue_fifo.sv
// Scoreboard bench for mul_issue_fifo: inputs change on the falling edge,
// outputs are sampled 1ns later.
module tb_mul_issue_fifo;
   import pipTypes::*;

   localparam int IQ    = 2;
   localparam int DEPTH = 1 << IQ;

   logic                     clock = 1'b0;
   logic                     reset_n;
   logic                     flush;
   logic                     in_valid;
   logic                     in_ready;
   dec_inst_t                in_inst;
   logic [31:0]              in_A, in_B;
   logic [ROB_DEPTHLOG2-1:0] in_rob_slot;
   fwd_info_t                in_fwd_info;
   logic                     out_valid;
   logic                     out_ready;
   dec_inst_t                out_inst;
   logic [31:0]              out_A, out_B;
   logic [ROB_DEPTHLOG2-1:0] out_rob_slot;
   fwd_info_t                out_fwd_info;
   logic [IQ:0]              count;

   int checks = 0;
   int errors = 0;
   iq_mul_entry_t mq[$];

   always #5 clock = ~clock;

   mul_issue_fifo #(.IQ_DEPTHLOG2(IQ)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_A(in_A), .in_B(in_B), .in_rob_slot(in_rob_slot), .in_fwd_info(in_fwd_info),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_A(out_A), .out_B(out_B), .out_rob_slot(out_rob_slot), .out_fwd_info(out_fwd_info),
      .count(count)
   );

   function automatic iq_mul_entry_t mk(input int s);
      iq_mul_entry_t e;
      e.inst.op            = md_op_t'(3'(s));
      e.inst.rd            = 5'(s + 1);
      e.a                  = 32'h1000_0000 + 32'(s);
      e.b                  = 32'hA5A5_0000 ^ 32'(s * 7);
      e.rob_slot           = ROB_DEPTHLOG2'(s);
      e.fwd_info.fwd_a     = s[0];
      e.fwd_info.rob_a     = ROB_DEPTHLOG2'(s + 5);
      e.fwd_info.fwd_b     = s[1];
      e.fwd_info.rob_b     = ROB_DEPTHLOG2'(s + 9);
      return e;
   endfunction

   // One cycle: drive, sample, compare flags and head against the scoreboard, update model.
   task automatic step(input logic v, input iq_mul_entry_t e, input logic rdy,
                       input logic fl, output logic acc);
      logic          exp_ir, exp_ov;
      iq_mul_entry_t got;
      @(negedge clock);
      in_valid    = v;
      in_inst     = e.inst;
      in_A        = e.a;
      in_B        = e.b;
      in_rob_slot = e.rob_slot;
      in_fwd_info = e.fwd_info;
      out_ready   = rdy;
      flush       = fl;
      #1;
      exp_ir = (mq.size() < DEPTH) && !fl;
      exp_ov = (mq.size() > 0) && !fl;
      checks++;
      if (in_ready !== exp_ir) begin
         errors++;
         $display("FAIL in_ready got %b want %b (occ %0d)", in_ready, exp_ir, mq.size());
      end
      checks++;
      if (out_valid !== exp_ov) begin
         errors++;
         $display("FAIL out_valid got %b want %b (occ %0d)", out_valid, exp_ov, mq.size());
      end
      checks++;
      if (count !== (IQ+1)'(mq.size())) begin
         errors++;
         $display("FAIL count got %0d want %0d", count, mq.size());
      end
      if (exp_ov) begin
         got = '{inst: out_inst, a: out_A, b: out_B, rob_slot: out_rob_slot, fwd_info: out_fwd_info};
         checks++;
         if (got !== mq[0]) begin
            errors++;
            $display("FAIL head_payload got %h want %h", got, mq[0]);
         end
      end
      acc = v && exp_ir;
      if (fl) mq.delete();
      else begin
         if (exp_ov && rdy) void'(mq.pop_front());
         if (acc) mq.push_back(e);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = '0; in_A = '0; in_B = '0; in_rob_slot = '0; in_fwd_info = '0;
      #3;
      checks++;
      if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL reset_outputs got ov=%b ir=%b cnt=%0d want ov=0 ir=1 cnt=0",
                  out_valid, in_ready, count);
      end
      @(negedge clock); @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      iq_mul_entry_t e;
      logic acc;
      e = mk(3);
      e.a = 32'h10;
      e.b = 32'h20;
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
      step(1'b1, e, 1'b1, 1'b0, acc);
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
      checks++;
      if (out_A !== 32'h10 || out_rob_slot !== 4'd3) begin
         errors++;
         $display("FAIL single_head got A=%h slot=%0d want A=10 slot=3", out_A, out_rob_slot);
      end
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
      checks++;
      if (count !== 3'd0) begin
         errors++;
         $display("FAIL single_drained count got %0d want 0", count);
      end
   endtask

   task automatic test_fill_drain();
      logic acc;
      int   s = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, mk(s), 1'b0, 1'b0, acc);
         if (acc) s++;
      end
      checks++;
      if (s != 4 || count !== 3'd4 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_full accepted %0d cnt=%0d ir=%b want 4 4 0", s, count, in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         step(s < 5, mk(s), 1'b1, 1'b0, acc);
         if (acc) s++;
      end
      checks++;
      if (s != 5 || mq.size() != 0) begin
         errors++;
         $display("FAIL fill_fifth accepted %0d left %0d want 5 0", s, mq.size());
      end
   endtask

   task automatic test_back_to_back();
      logic acc;
      for (int i = 0; i < 10; i++) step(1'b1, mk(20 + i), 1'b1, 1'b0, acc);
      checks++;
      if (count !== 3'd1) begin
         errors++;
         $display("FAIL b2b_count got %0d want 1", count);
      end
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
   endtask

   task automatic test_flush();
      logic acc;
      for (int i = 0; i < 3; i++) step(1'b1, mk(40 + i), 1'b0, 1'b0, acc);
      step(1'b1, mk(43), 1'b1, 1'b1, acc);
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty cnt=%0d ov=%b want 0 0", count, out_valid);
      end
      step(1'b1, mk(50), 1'b0, 1'b0, acc);
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
   endtask

   task automatic test_async_reset();
      logic acc;
      step(1'b1, mk(60), 1'b0, 1'b0, acc);
      step(1'b1, mk(61), 1'b0, 1'b0, acc);
      step(1'b0, mk(0), 1'b0, 1'b0, acc);
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL async_reset ov=%b cnt=%0d want 0 0", out_valid, count);
      end
      mq.delete();
      @(negedge clock);
      reset_n = 1'b1;
      step(1'b1, mk(70), 1'b0, 1'b0, acc);
      step(1'b1, mk(71), 1'b1, 1'b0, acc);
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
